// File: rtl/const_ext_unit.sv
// Registered immediate-extension unit for the ALU B-operand path.
// Zero/sign-extends an instruction immediate or joins it with a previously
// loaded prefix immediate to build a wide constant. One cycle latency,
// valid/ready on both sides, and the output holds while downstream stalls.
//
// state | meaning
// IDLE  | no prefix held; extend ops use the immediate alone
// PFX   | prefix held; next extend op combines {prefix, IM}
module const_ext_unit #(
  parameter int IMM_W  = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IMM_W-1:0]  IM,
  input  logic [1:0]        CS,
  input  logic              im_valid,
  output logic              im_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] cu_out,
  output logic              cu_valid,
  input  logic              cu_ready,
  output logic              pfx_pending,
  output logic              pfx_ovr
);

  localparam int CW = 2 * IMM_W;

  typedef enum logic {
    IDLE = 1'b0,
    PFX  = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IMM_W-1:0]   prefix;
  logic               accept;
  logic               is_pfx;
  logic               sx;
  logic [CW-1:0]      comb_c;
  logic [DATA_W-1:0]  ext_imm;
  logic [DATA_W-1:0]  ext_comb;
  logic [DATA_W-1:0]  ext_val;
  logic               ext_load;
  logic               pfx_load;
  logic               ovr_nxt;

  assign im_ready    = !flush && (!cu_valid || cu_ready);
  assign accept      = im_valid && im_ready;
  assign is_pfx      = (CS == 2'b10);
  assign sx          = (CS == 2'b01);
  assign pfx_pending = (state == PFX);
  assign comb_c      = {prefix, IM};

  // Mode 11 is reserved and falls through to zero-extension.
  assign ext_imm = {{(DATA_W-IMM_W){sx & IM[IMM_W-1]}}, IM};

  // Wide-constant formation depends on how DATA_W compares with two immediates.
  generate
    if (DATA_W > CW) begin : g_comb_ext
      assign ext_comb = {{(DATA_W-CW){sx & comb_c[CW-1]}}, comb_c};
    end else if (DATA_W == CW) begin : g_comb_eq
      assign ext_comb = comb_c;
    end else begin : g_comb_trunc
      assign ext_comb = comb_c[DATA_W-1:0];
    end
  endgenerate

  // Next-state and datapath-control decode.
  always_comb begin
    state_nxt = state;
    pfx_load  = 1'b0;
    ovr_nxt   = 1'b0;
    ext_load  = 1'b0;
    ext_val   = '0;
    if (flush) begin
      state_nxt = IDLE;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (is_pfx) begin
            pfx_load  = 1'b1;
            state_nxt = PFX;
          end else begin
            ext_load = 1'b1;
            ext_val  = ext_imm;
          end
        end
        PFX: begin
          if (is_pfx) begin
            pfx_load = 1'b1;
            ovr_nxt  = 1'b1;
          end else begin
            ext_load  = 1'b1;
            ext_val   = ext_comb;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register, prefix store and overwrite pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      prefix  <= '0;
      pfx_ovr <= 1'b0;
    end else begin
      state   <= state_nxt;
      pfx_ovr <= ovr_nxt;
      if (flush) begin
        prefix <= '0;
      end else if (pfx_load) begin
        prefix <= IM;
      end
    end
  end

  // Output register: load on extend op, hold under stall, drop once consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      cu_out   <= '0;
      cu_valid <= 1'b0;
    end else if (flush) begin
      cu_valid <= 1'b0;
    end else if (ext_load) begin
      cu_out   <= ext_val;
      cu_valid <= 1'b1;
    end else if (cu_ready) begin
      cu_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_const_ext_unit.sv
// Directed bench for const_ext_unit: one 8-bit and one 16-bit instance
// driven by the same stimulus, checked against hand-computed constants.
module tb_const_ext_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] IM;
  logic [1:0] CS;
  logic       im_valid;
  logic       flush;
  logic       cu_ready;

  logic        a_im_ready, a_cu_valid, a_pfx_pending, a_pfx_ovr;
  logic [7:0]  a_cu_out;
  logic        b_im_ready, b_cu_valid, b_pfx_pending, b_pfx_ovr;
  logic [15:0] b_cu_out;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  const_ext_unit #(.IMM_W(6), .DATA_W(8)) dut_a (
    .clk(clk), .reset(reset), .IM(IM), .CS(CS), .im_valid(im_valid),
    .im_ready(a_im_ready), .flush(flush), .cu_out(a_cu_out),
    .cu_valid(a_cu_valid), .cu_ready(cu_ready),
    .pfx_pending(a_pfx_pending), .pfx_ovr(a_pfx_ovr)
  );

  const_ext_unit #(.IMM_W(6), .DATA_W(16)) dut_b (
    .clk(clk), .reset(reset), .IM(IM), .CS(CS), .im_valid(im_valid),
    .im_ready(b_im_ready), .flush(flush), .cu_out(b_cu_out),
    .cu_valid(b_cu_valid), .cu_ready(cu_ready),
    .pfx_pending(b_pfx_pending), .pfx_ovr(b_pfx_ovr)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] cs, input logic [5:0] im);
    CS = cs;
    IM = im;
    im_valid = 1'b1;
    tick();
    im_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; IM = '0; CS = '0; im_valid = 1'b0; flush = 1'b0; cu_ready = 1'b1;
    tick();
    tick();
    chk("rst_out", {8'h0, a_cu_out}, 16'h0000);
    chk("rst_valid", {15'h0, a_cu_valid}, 16'h0);
    chk("rst_pend", {15'h0, a_pfx_pending}, 16'h0);
    chk("rst_ovr", {15'h0, a_pfx_ovr}, 16'h0);
    reset = 1'b0;
    #1;
    chk("rst_ready", {15'h0, a_im_ready}, 16'h1);

    // plain extension modes
    op(2'b00, 6'h25);
    chk("zx_a", {8'h0, a_cu_out}, 16'h0025);
    chk("zx_valid", {15'h0, a_cu_valid}, 16'h1);
    chk("zx_b", b_cu_out, 16'h0025);
    op(2'b01, 6'h25);
    chk("sx_a", {8'h0, a_cu_out}, 16'h00E5);
    chk("sx_b", b_cu_out, 16'hFFE5);
    op(2'b11, 6'h25);
    chk("rsv_a", {8'h0, a_cu_out}, 16'h0025);
    tick();
    chk("drain_valid", {15'h0, a_cu_valid}, 16'h0);

    // prefix with truncation (8) and extension (16)
    op(2'b10, 6'h03);
    chk("pfx_noout", {15'h0, a_cu_valid}, 16'h0);
    chk("pfx_pend1", {15'h0, a_pfx_pending}, 16'h1);
    tick();
    chk("pfx_hold", {15'h0, a_pfx_pending}, 16'h1);
    op(2'b00, 6'h2A);
    chk("pfx_a", {8'h0, a_cu_out}, 16'h00EA);
    chk("pfx_b", b_cu_out, 16'h00EA);
    chk("pfx_pend0", {15'h0, a_pfx_pending}, 16'h0);
    op(2'b10, 6'h3F);
    op(2'b01, 6'h01);
    chk("wide_sx_b", b_cu_out, 16'hFFC1);
    chk("wide_sx_a", {8'h0, a_cu_out}, 16'h00C1);
    op(2'b10, 6'h3F);
    op(2'b00, 6'h01);
    chk("wide_zx_b", b_cu_out, 16'h0FC1);
    tick();

    // downstream stall
    op(2'b00, 6'h25);
    cu_ready = 1'b0;
    CS = 2'b01; IM = 6'h3F; im_valid = 1'b1;
    #1;
    chk("stall_ready", {15'h0, a_im_ready}, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", {8'h0, a_cu_out}, 16'h0025);
      chk("stall_valid", {15'h0, a_cu_valid}, 16'h1);
    end
    cu_ready = 1'b1;
    #1;
    chk("unstall_ready", {15'h0, a_im_ready}, 16'h1);
    tick();
    im_valid = 1'b0;
    chk("unstall_a", {8'h0, a_cu_out}, 16'h00FF);
    chk("unstall_b", b_cu_out, 16'hFFFF);
    tick();

    // overwrite: prefix must end as 02
    op(2'b10, 6'h01);
    chk("ovr_quiet", {15'h0, a_pfx_ovr}, 16'h0);
    op(2'b10, 6'h02);
    chk("ovr_pulse", {15'h0, a_pfx_ovr}, 16'h1);
    op(2'b00, 6'h00);
    chk("ovr_clear", {15'h0, a_pfx_ovr}, 16'h0);
    chk("ovr_val", {8'h0, a_cu_out}, 16'h0080);
    tick();

    // overwrite then flush with an op presented
    op(2'b10, 6'h01);
    op(2'b10, 6'h02);
    flush = 1'b1; CS = 2'b00; IM = 6'h3F; im_valid = 1'b1;
    #1;
    chk("flush_ready", {15'h0, a_im_ready}, 16'h0);
    tick();
    flush = 1'b0; im_valid = 1'b0;
    chk("flush_pend", {15'h0, a_pfx_pending}, 16'h0);
    chk("flush_valid", {15'h0, a_cu_valid}, 16'h0);
    op(2'b00, 6'h05);
    chk("post_flush_a", {8'h0, a_cu_out}, 16'h0005);
    chk("post_flush_b", b_cu_out, 16'h0005);
    tick();

    // reset mid-operation
    op(2'b00, 6'h25);
    cu_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_out", {8'h0, a_cu_out}, 16'h0000);
    chk("mrst_valid", {15'h0, a_cu_valid}, 16'h0);
    cu_ready = 1'b1;
    op(2'b10, 6'h07);
    cu_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_pend", {15'h0, a_pfx_pending}, 16'h0);
    chk("mrst_ovr", {15'h0, a_pfx_ovr}, 16'h0);
    cu_ready = 1'b1;
    op(2'b01, 6'h20);
    chk("mrst_next_a", {8'h0, a_cu_out}, 16'h00E0);
    chk("mrst_next_b", b_cu_out, 16'hFFE0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/const_ext_unit.md
Name: const_ext_unit

Overview:
- Parametrised, registered immediate-extension unit for the MCU datapath; feeds the ALU B-operand mux.
- Takes an IMM_W-bit instruction immediate and produces a DATA_W-bit constant: zero-extended, sign-extended, or concatenated with a previously loaded prefix immediate (two-instruction wide constants).
- Valid/ready handshake on both sides; 1-cycle latency; output holds under downstream stall.

Parameters:
- IMM_W, 6, immediate field width (>=2)
- DATA_W, 8, output constant width (IMM_W < DATA_W <= 4*IMM_W)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- IM  input  IMM_W  instruction immediate field
- CS  input  2  mode: 00 zero-extend, 01 sign-extend, 10 load prefix, 11 reserved (treated as 00)
- im_valid  input  1  IM/CS valid this cycle
- im_ready  output  1  unit accepts IM/CS this cycle
- flush  input  1  pipeline flush; discard prefix and pending output
- cu_out  output  DATA_W  extended constant
- cu_valid  output  1  cu_out valid
- cu_ready  input  1  downstream accepts cu_out
- pfx_pending  output  1  a prefix is held
- pfx_ovr  output  1  one-cycle pulse: a prefix overwrote an unconsumed prefix

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset: cu_out=0, cu_valid=0, pfx_pending=0, pfx_ovr=0, prefix register=0, FSM=IDLE. A reset asserted mid-operation discards any held prefix and any pending output in that edge.
- Ready rule: im_ready = !flush && (!cu_valid || cu_ready). An input is accepted when im_valid && im_ready.
- Output register:
  - On an accepted extend op (CS != 10), cu_out and cu_valid=1 are loaded at the next edge. Latency is 1 cycle.
  - If cu_valid && !cu_ready, cu_out and cu_valid hold unchanged.
  - If cu_ready with no new extend op accepted, cu_valid clears.
- FSM, two states, IDLE and PFX:
  - IDLE + accepted CS=10: prefix<=IM, go to PFX, pfx_pending=1. No output is produced; cu_valid follows the output-register rules.
  - IDLE + accepted CS=00/11: cu_out = {(DATA_W-IMM_W){0}, IM}.
  - IDLE + accepted CS=01: cu_out = {(DATA_W-IMM_W){IM[IMM_W-1]}, IM}.
  - PFX + accepted CS=10: prefix<=IM, stay in PFX, pfx_ovr=1 for one cycle.
  - PFX + accepted CS!=10: form combined C = {prefix, IM} (2*IMM_W bits).
    - If DATA_W >= 2*IMM_W, extend C to DATA_W: zero-extend for 00/11, sign-extend from C[2*IMM_W-1] for 01.
    - Otherwise cu_out = C[DATA_W-1:0], regardless of mode.
    - Go to IDLE and clear pfx_pending.
  - In any state, no accepted input means the state is held.
- Flush, synchronous and priority over everything except reset:
  - Next edge: cu_valid=0, FSM=IDLE, pfx_pending=0.
  - The input presented that cycle is not accepted (im_ready=0).
  - cu_out value need not change.
- pfx_ovr is 0 in every cycle other than the overwrite pulse.
- Purely synchronous; no combinational path from IM to cu_out.

Test Plan:
- Defaults. IM=6'h25, CS=00, valid, cu_ready=1 -> next cycle cu_out=8'h25, cu_valid=1. Same IM with CS=01 -> 8'hE5. CS=11 -> 8'h25.
- Prefix, DATA_W=8. CS=10 IM=6'h03, then CS=00 IM=6'h2A -> no output after the first op; cu_out=8'hEA after the second; pfx_pending goes 1 then 0.
- Prefix, DATA_W=16. CS=10 IM=6'h3F, then CS=01 IM=6'h01 -> cu_out=16'hFFC1. Repeat with CS=00 -> 16'h0FC1.
- Stall. cu_ready=0 after a result 8'h25 while a new op (CS=01, IM=6'h3F) is offered -> im_ready=0 and cu_out holds 8'h25 for 3 cycles. Raise cu_ready -> 8'h25 is consumed, then next cu_out=8'hFF.
- Overwrite and flush. Two consecutive CS=10 ops (6'h01, 6'h02) -> pfx_ovr pulses 1 cycle and the prefix becomes 6'h02. Flush next cycle -> pfx_pending=0 and cu_valid=0. A following CS=00 IM=6'h05 -> 8'h05, with no prefix applied.
- Reset mid-operation. Pending prefix plus cu_valid=1 with cu_ready=0, then assert reset for 1 cycle -> all outputs 0 and state IDLE; the next CS=01 IM=6'h20 -> 8'hE0.
